branch_tag_mgr: RTL and testbench
=================================

# branch_tag_mgr

- Allocates, tracks and retires the four speculative branch tags used by the ALU and LS reservation stations.
- Gives the dispatcher a tag index for each new branch and the dependency mask for every dispatched instruction.
- Turns branch-unit resolutions into the registered `bFreeEn`/`bFreeNum`/`misTaken` broadcast that the RS lines use to clear tag bits or discard wrong-path entries.
- Sits between dispatcher, branch unit and all reservation stations.

## Interface
Parameters:
- `TAG_NUM`, 4: number of branch tags; must equal width of `BranchTagBus`.
- `TAG_IDX_W`, 2: tag index width; must equal width of `bFreeNum`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-low.
- `rdy`  in  1  global ready; when low, all state and registered outputs hold.
- `allocReq`  in  1  dispatcher requests a tag for a branch dispatched this cycle.
- `allocGrant`  out  1  combinational grant; a tag is consumed only when `allocReq & allocGrant`.
- `allocNum`  out  2  combinational index of the granted tag.
- `curMask`  out  `BranchTagBus`  combinational mask of outstanding branch tags; attached to every instruction dispatched this cycle.
- `tagFull`  out  1  combinational; no free tag.
- `resolveEn`  in  1  branch unit resolves a tag this cycle.
- `resolveNum`  in  2  tag being resolved.
- `resolveMis`  in  1  resolution is a misprediction.
- `bFreeEn`  out  1  registered broadcast valid.
- `bFreeNum`  out  2  registered broadcast tag.
- `misTaken`  out  1  registered; broadcast is a misprediction.

## Operation
State:
- `validMask[3:0]`: outstanding tags.
- `depMask[k][3:0]` per tag: tags outstanding when tag k was allocated.

Allocation:
- `allocGrant = ~tagFull & ~misTaken & rdy`.
- `allocNum` = lowest-index clear bit of `validMask`.
- On an accepted allocation: `validMask[allocNum] <= 1` and `depMask[allocNum] <= curMask`.
- `curMask = validMask`. It excludes the tag being allocated this cycle: the branch itself does not depend on its own tag.

Correct resolve (`resolveEn & ~resolveMis`, `validMask[resolveNum]==1`):
- Clear bit `resolveNum` in `validMask` and in every `depMask[j]`.
- Register `bFreeEn=1`, `bFreeNum=resolveNum`, `misTaken=0`.

Mispredict resolve (`resolveEn & resolveMis`, tag valid):
- Clear bit `resolveNum` in `validMask`.
- Also clear every tag j whose `depMask[j][resolveNum]==1`; these are younger branches, killed.
- Register `bFreeEn=1`, `bFreeNum=resolveNum`, `misTaken=1`.
- RS entries of killed branches carry bit `resolveNum`, so a single broadcast discards them.

Other resolve cases:
- Resolve of a tag with `validMask` bit 0 (already killed) is ignored; the broadcast registers 0.
- No resolve: broadcast registers `bFreeEn=0`, `bFreeNum=0`, `misTaken=0`.

Simultaneous events:
- Alloc + correct resolve in the same cycle: both apply. A tag freed this cycle is not grantable until the next cycle, because `allocNum` uses the pre-update mask. The new `depMask` entry has the resolved bit cleared.
- Alloc is blocked whenever `misTaken` is high, so an allocation never coincides with a mispredict broadcast.

## Timing
- Reset (`rst==0` at posedge): `validMask=0`, all `depMask=0`, `bFreeEn=0`, `bFreeNum=0`, `misTaken=0`.
- Combinational outputs after reset: `allocNum=0`, `tagFull=0`, `curMask=0`. `allocGrant` equals `rdy`.
- Allocation latency: 0 cycles for the grant; `validMask` updates at the next edge.
- Resolve→broadcast latency: 1 cycle. The broadcast is high for exactly one cycle per valid resolve.
- `validMask` clears at the same edge the broadcast registers, so `curMask` in the broadcast cycle already lacks the freed bit. RS lines that allocate in that cycle load a clean mask.
- After a mispredict, `allocGrant` is low for exactly the broadcast cycle.
- With `rdy==0`, inputs are ignored and the broadcast registers hold their value.

## Configuration
- `BTAG_PERF_EN` defined: adds 32-bit output counters `resolveCnt` and `misCnt`.
  - Each increments by 1 per valid correct resolve or valid mispredict resolve respectively.
  - Both reset to 0 and wrap modulo 2^32.
- `BTAG_PERF_EN` undefined: the ports and logic do not exist. All other behaviour is identical.

## Test plan
- Reset, then hold `allocReq` for 5 cycles → grants with `allocNum` 0,1,2,3; 5th cycle `tagFull=1`, `allocGrant=0`; `curMask` steps 0000,0001,0011,0111,1111.
- Tags 0–3 outstanding; correct-resolve tag 1 → next cycle `bFreeEn=1`, `bFreeNum=1`, `misTaken=0`, `curMask=1101`; next alloc gets `allocNum=1`.
- Tags 0–3 allocated in order; mispredict tag 1 → next cycle `misTaken=1`, `bFreeNum=1`, `allocGrant=0`, `validMask=0001`; cycle after, `allocNum=1`.
- Same cycle: tags 0,1 outstanding, `allocReq` plus correct resolve of tag 0 → grant `allocNum=2` with `depMask[2]=0010`; next `curMask=0110`.
- Resolve of a killed tag 3 right after a mispredict of tag 1 → no broadcast (`bFreeEn=0`), state unchanged.
- `BTAG_PERF_EN`: 3 correct + 2 mispredict resolves → `resolveCnt=3`, `misCnt=2`. Drive `rst=0` mid-sequence → all counters and `validMask` are 0 after the edge.

Source files
------------

// File: rtl/branch_tag_mgr_if.sv
// Dispatcher / branch-unit side of the branch tag manager: allocation handshake,
// resolution input and the registered free/mispredict broadcast to the RS lines.
interface branch_tag_mgr_if #(
  parameter int TAG_NUM   = 4,
  parameter int TAG_IDX_W = 2
);
  logic                 allocReq;
  logic                 allocGrant;
  logic [TAG_IDX_W-1:0] allocNum;
  logic [TAG_NUM-1:0]   curMask;
  logic                 tagFull;
  logic                 resolveEn;
  logic [TAG_IDX_W-1:0] resolveNum;
  logic                 resolveMis;
  logic                 bFreeEn;
  logic [TAG_IDX_W-1:0] bFreeNum;
  logic                 misTaken;

  modport master (
    output allocReq, resolveEn, resolveNum, resolveMis,
    input  allocGrant, allocNum, curMask, tagFull, bFreeEn, bFreeNum, misTaken
  );

  modport slave (
    input  allocReq, resolveEn, resolveNum, resolveMis,
    output allocGrant, allocNum, curMask, tagFull, bFreeEn, bFreeNum, misTaken
  );
endinterface

// File: rtl/branch_tag_mgr.sv
// Speculative branch tag allocator: 0-cycle grant, 1-cycle registered free/kill broadcast;
// rdy low freezes everything. Define BTAG_PERF_EN to add resolveCnt/misCnt counters.
module branch_tag_mgr #(
  parameter int TAG_NUM   = 4,
  parameter int TAG_IDX_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  branch_tag_mgr_if.slave bus
`ifdef BTAG_PERF_EN
  ,
  output logic [31:0]     resolveCnt,
  output logic [31:0]     misCnt
`endif
);

  typedef logic [TAG_NUM-1:0] tag_mask_t;

  tag_mask_t            validMask;
  tag_mask_t            depMask [TAG_NUM];
  logic [TAG_IDX_W-1:0] freeNum;
  logic                 full;
  logic                 grant;
  logic                 allocFire;
  logic                 resValid;
  logic                 resMis;
  tag_mask_t            resBit;
  tag_mask_t            clrBit;
  tag_mask_t            allocBit;
  tag_mask_t            killMask;
  tag_mask_t            nextValid;

  always_comb begin
    freeNum = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (!validMask[i]) freeNum = TAG_IDX_W'(i);
    end
  end

  assign full      = &validMask;
  assign grant     = ~full & ~bus.misTaken & rdy;
  assign allocFire = bus.allocReq & grant;

  assign bus.allocGrant = grant;
  assign bus.allocNum   = freeNum;
  assign bus.curMask    = validMask;
  assign bus.tagFull    = full;

  assign resValid = bus.resolveEn & validMask[bus.resolveNum];
  assign resMis   = resValid & bus.resolveMis;
  assign resBit   = tag_mask_t'(1) << bus.resolveNum;
  assign clrBit   = resValid ? resBit : '0;
  assign allocBit = allocFire ? (tag_mask_t'(1) << freeNum) : '0;

  always_comb begin
    killMask = clrBit;
    if (resMis) begin
      for (int j = 0; j < TAG_NUM; j++) begin
        if (depMask[j][bus.resolveNum]) killMask[j] = 1'b1;
      end
      // A branch granted in the mispredict cycle is younger than the bad tag: kill it too.
      killMask = killMask | allocBit;
    end
    nextValid = (validMask | allocBit) & ~killMask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      validMask    <= '0;
      for (int j = 0; j < TAG_NUM; j++) depMask[j] <= '0;
      bus.bFreeEn  <= 1'b0;
      bus.bFreeNum <= '0;
      bus.misTaken <= 1'b0;
    end else if (rdy) begin
      validMask <= nextValid;
      for (int j = 0; j < TAG_NUM; j++) begin
        if (allocBit[j]) depMask[j] <= validMask & ~clrBit;
        else             depMask[j] <= depMask[j] & ~clrBit;
      end
      bus.bFreeEn  <= resValid;
      bus.bFreeNum <= resValid ? bus.resolveNum : '0;
      bus.misTaken <= resMis;
    end
  end

`ifdef BTAG_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      resolveCnt <= '0;
      misCnt     <= '0;
    end else if (rdy) begin
      if (resValid && !bus.resolveMis) resolveCnt <= resolveCnt + 32'd1;
      if (resMis)                      misCnt     <= misCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_tag_mgr.sv
// Directed bench for branch_tag_mgr: allocation order, correct/mispredict resolves,
// same-cycle alloc+resolve, killed-tag resolve, rdy hold and optional perf counters.
module tb_branch_tag_mgr;
  logic clk;
  logic rst;
  logic rdy;
  int   tests;
  int   fails;

  branch_tag_mgr_if #(.TAG_NUM(4), .TAG_IDX_W(2)) bus ();

`ifdef BTAG_PERF_EN
  logic [31:0] resolveCnt;
  logic [31:0] misCnt;
  branch_tag_mgr #(.TAG_NUM(4), .TAG_IDX_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave),
    .resolveCnt(resolveCnt), .misCnt(misCnt)
  );
`else
  branch_tag_mgr #(.TAG_NUM(4), .TAG_IDX_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    rdy = 1'b1;
    bus.allocReq   = 1'b0;
    bus.resolveEn  = 1'b0;
    bus.resolveNum = 2'd0;
    bus.resolveMis = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_allocNum", 32'(bus.allocNum), 32'd0);
    chk("rst_tagFull",  32'(bus.tagFull),  32'd0);
    chk("rst_curMask",  32'(bus.curMask),  32'd0);
    chk("rst_bFreeEn",  32'(bus.bFreeEn),  32'd0);
    chk("rst_bFreeNum", 32'(bus.bFreeNum), 32'd0);
    chk("rst_misTaken", 32'(bus.misTaken), 32'd0);
    chk("rst_grant_rdy1", 32'(bus.allocGrant), 32'd1);
    rdy = 1'b0;
    #1;
    chk("rst_grant_rdy0", 32'(bus.allocGrant), 32'd0);
    rdy = 1'b1;

    // Fill all four tags, then observe full on the fifth request.
    bus.allocReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fill_curMask", 32'(bus.curMask), 32'((1 << i) - 1));
      chk("fill_tagFull", 32'(bus.tagFull), (i == 4) ? 32'd1 : 32'd0);
      chk("fill_grant",   32'(bus.allocGrant), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("fill_allocNum", 32'(bus.allocNum), 32'(i));
      tick();
    end
    bus.allocReq = 1'b0;

    // Correct resolve of tag 1.
    bus.resolveEn  = 1'b1;
    bus.resolveNum = 2'd1;
    bus.resolveMis = 1'b0;
    tick();
    bus.resolveEn = 1'b0;
    #1;
    chk("cor_bFreeEn",  32'(bus.bFreeEn),  32'd1);
    chk("cor_bFreeNum", 32'(bus.bFreeNum), 32'd1);
    chk("cor_misTaken", 32'(bus.misTaken), 32'd0);
    chk("cor_curMask",  32'(bus.curMask),  32'hD);
    bus.allocReq = 1'b1;
    #1;
    chk("cor_allocNum", 32'(bus.allocNum),   32'd1);
    chk("cor_grant",    32'(bus.allocGrant), 32'd1);
    tick();
    bus.allocReq = 1'b0;
    #1;
    chk("cor_refill_curMask", 32'(bus.curMask), 32'hF);
    chk("cor_bFreeEn_pulse",  32'(bus.bFreeEn), 32'd0);

    // Mispredict tag 1 with chain 0<-1<-2<-3, then resolve killed tag 3.
    do_reset();
    bus.allocReq = 1'b1;
    repeat (4) tick();
    bus.allocReq = 1'b0;
    #1;
    chk("mis_pre_curMask", 32'(bus.curMask), 32'hF);
    bus.resolveEn  = 1'b1;
    bus.resolveNum = 2'd1;
    bus.resolveMis = 1'b1;
    tick();
    bus.resolveNum = 2'd3;
    bus.resolveMis = 1'b0;
    #1;
    chk("mis_misTaken", 32'(bus.misTaken),   32'd1);
    chk("mis_bFreeEn",  32'(bus.bFreeEn),    32'd1);
    chk("mis_bFreeNum", 32'(bus.bFreeNum),   32'd1);
    chk("mis_grant",    32'(bus.allocGrant), 32'd0);
    chk("mis_curMask",  32'(bus.curMask),    32'h1);
    tick();
    bus.resolveEn = 1'b0;
    #1;
    chk("killed_bFreeEn",  32'(bus.bFreeEn),    32'd0);
    chk("killed_misTaken", 32'(bus.misTaken),   32'd0);
    chk("killed_curMask",  32'(bus.curMask),    32'h1);
    chk("killed_allocNum", 32'(bus.allocNum),   32'd1);
    chk("killed_grant",    32'(bus.allocGrant), 32'd1);

    // Same-cycle alloc and correct resolve of tag 0.
    do_reset();
    bus.allocReq = 1'b1;
    repeat (2) tick();
    bus.resolveEn  = 1'b1;
    bus.resolveNum = 2'd0;
    bus.resolveMis = 1'b0;
    #1;
    chk("same_allocNum", 32'(bus.allocNum),   32'd2);
    chk("same_grant",    32'(bus.allocGrant), 32'd1);
    chk("same_curMask",  32'(bus.curMask),    32'h3);
    tick();
    bus.allocReq  = 1'b0;
    bus.resolveEn = 1'b0;
    #1;
    chk("same_next_curMask", 32'(bus.curMask),      32'h6);
    chk("same_depMask2",     32'(dut.depMask[2]),   32'h2);
    chk("same_bFreeEn",      32'(bus.bFreeEn),      32'd1);
    chk("same_bFreeNum",     32'(bus.bFreeNum),     32'd0);
    bus.resolveEn  = 1'b1;
    bus.resolveNum = 2'd1;
    bus.resolveMis = 1'b1;
    tick();
    bus.resolveEn = 1'b0;
    #1;
    chk("dep_kill_curMask",  32'(bus.curMask),  32'h0);
    chk("dep_kill_misTaken", 32'(bus.misTaken), 32'd1);

    // rdy low freezes state and broadcast.
    rdy = 1'b0;
    bus.allocReq   = 1'b1;
    bus.resolveEn  = 1'b1;
    bus.resolveNum = 2'd0;
    bus.resolveMis = 1'b0;
    tick();
    #1;
    chk("hold_bFreeEn",  32'(bus.bFreeEn),    32'd1);
    chk("hold_misTaken", 32'(bus.misTaken),   32'd1);
    chk("hold_bFreeNum", 32'(bus.bFreeNum),   32'd1);
    chk("hold_curMask",  32'(bus.curMask),    32'h0);
    chk("hold_grant",    32'(bus.allocGrant), 32'd0);
    rdy = 1'b1;
    bus.allocReq  = 1'b0;
    bus.resolveEn = 1'b0;
    tick();
    #1;
    chk("release_bFreeEn", 32'(bus.bFreeEn), 32'd0);

`ifdef BTAG_PERF_EN
    do_reset();
    bus.allocReq = 1'b1;
    repeat (4) tick();
    bus.allocReq   = 1'b0;
    bus.resolveEn  = 1'b1;
    bus.resolveMis = 1'b0;
    bus.resolveNum = 2'd3;
    tick();
    bus.resolveNum = 2'd2;
    tick();
    bus.resolveNum = 2'd1;
    tick();
    bus.resolveNum = 2'd0;
    bus.resolveMis = 1'b1;
    tick();
    bus.resolveEn = 1'b0;
    tick();
    bus.allocReq = 1'b1;
    tick();
    bus.allocReq   = 1'b0;
    bus.resolveEn  = 1'b1;
    bus.resolveNum = 2'd0;
    bus.resolveMis = 1'b1;
    tick();
    bus.resolveEn = 1'b0;
    #1;
    chk("perf_resolveCnt", resolveCnt, 32'd3);
    chk("perf_misCnt",     misCnt,     32'd2);
    bus.allocReq = 1'b1;
    tick();
    tick();
    bus.allocReq = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("perf_rst_resolveCnt", resolveCnt, 32'd0);
    chk("perf_rst_misCnt",     misCnt,     32'd0);
    chk("perf_rst_curMask",    32'(bus.curMask), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
